// File: rtl/pc_redirect_queue.sv
// pc_redirect_queue: delay-slot redirect controller for the MIPS PC path.
// Holds a branch/jump target for DELAY_SLOTS slots, annuls likely slots.
module pc_redirect_queue #(
  parameter int WIDTH       = 32,
  parameter int DELAY_SLOTS = 1,
  parameter int CW          = $clog2(DELAY_SLOTS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             redirect_req,
  input  logic             redirect_taken,
  input  logic             redirect_likely,
  input  logic             flush,
  input  logic [WIDTH-1:0] tgt_addr,
  input  logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] next_pc,
  output logic             delay,
  output logic             annul,
  output logic             redirect_fire,
  output logic [CW-1:0]    slots_left,
  output logic             overlap_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ANNUL   = 2'd2
  } state_e;

  localparam logic [CW-1:0] SLOTS = CW'(DELAY_SLOTS);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] held_tgt_q, held_tgt_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovl_q, ovl_d;

  logic last_slot;
  assign last_slot = (count_q == ONE);

  // Next-state: flush wins even while stalled; stalls hold everything.
  always_comb begin
    state_d    = state_q;
    held_tgt_d = held_tgt_q;
    count_d    = count_q;
    ovl_d      = ovl_q;
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else if (clk_enable) begin
      unique case (state_q)
        IDLE: begin
          if (redirect_req) begin
            if (redirect_taken) begin
              state_d    = PENDING;
              held_tgt_d = tgt_addr;
              count_d    = SLOTS;
            end else if (redirect_likely) begin
              state_d = ANNUL;
              count_d = SLOTS;
            end
          end
        end
        PENDING, ANNUL: begin
          if (redirect_req) begin
            ovl_d = 1'b1;
          end
          if (last_slot) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q - ONE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      held_tgt_q <= '0;
      count_q    <= '0;
      ovl_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_tgt_q <= held_tgt_d;
      count_q    <= count_d;
      ovl_q      <= ovl_d;
    end
  end

  // Moore decode of slot status; next_pc only mixes in pc_plus4.
  always_comb begin
    next_pc       = pc_plus4;
    delay         = 1'b0;
    annul         = 1'b0;
    redirect_fire = 1'b0;
    slots_left    = '0;
    unique case (state_q)
      PENDING: begin
        delay      = 1'b1;
        slots_left = count_q;
        if (last_slot) begin
          redirect_fire = 1'b1;
          next_pc       = held_tgt_q;
        end
      end
      ANNUL: begin
        annul      = 1'b1;
        slots_left = count_q;
      end
      default: begin
        next_pc = pc_plus4;
      end
    endcase
  end

  assign overlap_err = ovl_q;

endmodule
